// File: rtl/udp_axis_pkg.sv
// Shared definitions for the UDP/IP AXI-Stream TX path: bus widths, arbiter
// state encoding and the keep-to-byte-count helper used by the byte counters.
package udp_axis_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } arb_state_e;

    // Only contiguous LSB-aligned masks carry bytes; anything else counts zero.
    function automatic logic [3:0] kb(input logic [AXIS_KEEP_W-1:0] keep);
        logic [3:0] n;
        case (keep)
            8'h01:   n = 4'd1;
            8'h03:   n = 4'd2;
            8'h07:   n = 4'd3;
            8'h0F:   n = 4'd4;
            8'h1F:   n = 4'd5;
            8'h3F:   n = 4'd6;
            8'h7F:   n = 4'd7;
            8'hFF:   n = 4'd8;
            default: n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first asserted request searching upward
// from last+1, wrapping modulo NUM_SRC.
module rr_select #(
    parameter int NUM_SRC = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         last,
    output logic [1:0]         gnt_idx,
    output logic               any
);

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        for (int off = 1; off <= NUM_SRC; off++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!any && req[i] && (i == ((int'(last) + off) % NUM_SRC))) begin
                    any     = 1'b1;
                    gnt_idx = 2'(i);
                end
            end
        end
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin merge of NUM_SRC AXI-Stream sources, with a
// per-packet byte-length and source report for TX statistics.
module axis_pkt_arbiter
    import udp_axis_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int LEN_W   = 16
) (
    input  logic                           axis_aclk,
    input  logic                           axis_aresetn,
    input  logic [NUM_SRC-1:0]             s_axis_tvalid,
    output logic [NUM_SRC-1:0]             s_axis_tready,
    input  logic [NUM_SRC*AXIS_DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_SRC*AXIS_KEEP_W-1:0] s_axis_tkeep,
    input  logic [NUM_SRC-1:0]             s_axis_tlast,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [AXIS_DATA_W-1:0]         m_axis_tdata,
    output logic [AXIS_KEEP_W-1:0]         m_axis_tkeep,
    output logic                           m_axis_tlast,
    output logic [LEN_W-1:0]               pkt_len_bytes,
    output logic [1:0]                     pkt_src,
    output logic                           pkt_done
);

    arb_state_e             state_q, state_d;
    logic [1:0]             grant_q, grant_d;
    logic [1:0]             last_grant_q, last_grant_d;
    logic [LEN_W-1:0]       acc_q, acc_d;
    logic [LEN_W-1:0]       pkt_len_q, pkt_len_d;
    logic [1:0]             pkt_src_q, pkt_src_d;
    logic                   pkt_done_q, pkt_done_d;

    logic [1:0]             sel_idx;
    logic                   sel_any;
    logic                   busy;
    logic                   sel_valid;
    logic [AXIS_DATA_W-1:0] sel_data;
    logic [AXIS_KEEP_W-1:0] sel_keep;
    logic                   sel_last;
    logic                   beat_fire;
    logic [LEN_W-1:0]       beat_sum;

    rr_select #(
        .NUM_SRC(NUM_SRC)
    ) u_rr_select (
        .req     (s_axis_tvalid),
        .last    (last_grant_q),
        .gnt_idx (sel_idx),
        .any     (sel_any)
    );

    assign busy = (state_q == ST_BUSY);

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == 2'(i)) begin
                sel_valid = s_axis_tvalid[i];
                sel_data  = s_axis_tdata[i*AXIS_DATA_W +: AXIS_DATA_W];
                sel_keep  = s_axis_tkeep[i*AXIS_KEEP_W +: AXIS_KEEP_W];
                sel_last  = s_axis_tlast[i];
            end
        end
    end

    // Outputs are forced to zero outside BUSY so reset clears them immediately.
    always_comb begin
        m_axis_tvalid = busy & sel_valid;
        m_axis_tdata  = busy ? sel_data : '0;
        m_axis_tkeep  = busy ? sel_keep : '0;
        m_axis_tlast  = busy & sel_last;
        s_axis_tready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s_axis_tready[i] = busy && (grant_q == 2'(i)) && m_axis_tready;
        end
    end

    assign beat_fire = m_axis_tvalid & m_axis_tready;
    assign beat_sum  = acc_q + LEN_W'(kb(sel_keep));

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        acc_d        = acc_q;
        pkt_len_d    = pkt_len_q;
        pkt_src_d    = pkt_src_q;
        pkt_done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_any) begin
                    grant_d = sel_idx;
                    acc_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (beat_fire) begin
                    if (sel_last) begin
                        pkt_len_d    = beat_sum;
                        pkt_src_d    = grant_q;
                        pkt_done_d   = 1'b1;
                        last_grant_d = grant_q;
                        acc_d        = '0;
                        state_d      = ST_IDLE;
                    end else begin
                        acc_d = beat_sum;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // last_grant resets to the top index so source 0 wins the first arbitration.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= 2'(NUM_SRC - 1);
            acc_q        <= '0;
            pkt_len_q    <= '0;
            pkt_src_q    <= '0;
            pkt_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            acc_q        <= acc_d;
            pkt_len_q    <= pkt_len_d;
            pkt_src_q    <= pkt_src_d;
            pkt_done_q   <= pkt_done_d;
        end
    end

    assign pkt_len_bytes = pkt_len_q;
    assign pkt_src       = pkt_src_q;
    assign pkt_done      = pkt_done_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed self-checking bench for axis_pkt_arbiter with two sources: single
// packet, fairness, stall/backpressure, keep decoding, wrap and mid-packet reset.
module tb_axis_pkt_arbiter;

    localparam int NUM_SRC = 2;
    localparam int LEN_W   = 16;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
        int          src;
        int          cyc;
    } out_t;

    typedef struct {
        logic [15:0] len;
        logic [1:0]  src;
    } done_t;

    logic                   clk;
    logic                   rst_n;
    logic [NUM_SRC-1:0]     s_tvalid;
    logic [NUM_SRC-1:0]     s_tready;
    logic [NUM_SRC*64-1:0]  s_tdata;
    logic [NUM_SRC*8-1:0]   s_tkeep;
    logic [NUM_SRC-1:0]     s_tlast;
    logic                   m_tvalid;
    logic                   m_tready;
    logic [63:0]            m_tdata;
    logic [7:0]             m_tkeep;
    logic                   m_tlast;
    logic [LEN_W-1:0]       len_out;
    logic [1:0]             src_out;
    logic                   done_out;

    beat_t src_q [NUM_SRC][$];
    out_t  out_log[$];
    done_t done_log[$];

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    int hold_cnt = 0;
    int hold_trig = -1;
    int toggle_rdy = 0;
    int watch_ready0 = 0;
    int ready0_hits = 0;
    int req_cyc;

    axis_pkt_arbiter #(
        .NUM_SRC(NUM_SRC),
        .LEN_W  (LEN_W)
    ) dut (
        .axis_aclk     (clk),
        .axis_aresetn  (rst_n),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .pkt_len_bytes (len_out),
        .pkt_src       (src_out),
        .pkt_done      (done_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_data(input int s, input int p, input int b);
        return 64'hD000_0000_0000_0000 | (64'(s) << 40) | (64'(p) << 16) | 64'(b);
    endfunction

    function automatic done_t get_done(input int k);
        done_t d;
        d.len = '1;
        d.src = '1;
        if (k < done_log.size()) d = done_log[k];
        return d;
    endfunction

    function automatic out_t get_out(input int k);
        out_t o;
        o.data = '1;
        o.last = 1'b1;
        o.src  = -1;
        o.cyc  = -1000;
        if (k < out_log.size()) o = out_log[k];
        return o;
    endfunction

    task automatic push_beat(input int s, input logic [63:0] d, input logic [7:0] k, input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        src_q[s].push_back(b);
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_q[i].size() > 0) begin
                s_tvalid[i]        = !(i == 1 && hold_cnt > 0);
                s_tdata[i*64 +: 64] = src_q[i][0].data;
                s_tkeep[i*8 +: 8]   = src_q[i][0].keep;
                s_tlast[i]          = src_q[i][0].last;
            end else begin
                s_tvalid[i]        = 1'b0;
                s_tdata[i*64 +: 64] = '0;
                s_tkeep[i*8 +: 8]   = '0;
                s_tlast[i]          = 1'b0;
            end
        end
    endtask

    // One clock cycle: observe at the falling edge, advance sources after the rising edge.
    task automatic tick();
        logic [NUM_SRC-1:0] hs;
        out_t  ob;
        done_t dn;
        @(negedge clk);
        hs = s_tvalid & s_tready;
        if (m_tvalid && m_tready) begin
            ob.data = m_tdata;
            ob.last = m_tlast;
            ob.src  = -1;
            ob.cyc  = cycle;
            for (int i = 0; i < NUM_SRC; i++) if (hs[i]) ob.src = i;
            out_log.push_back(ob);
        end
        if (done_out) begin
            dn.len = len_out;
            dn.src = src_out;
            done_log.push_back(dn);
        end
        if (watch_ready0 != 0 && done_log.size() == 0 && s_tready[0]) ready0_hits++;
        @(posedge clk);
        #1;
        cycle++;
        for (int i = 0; i < NUM_SRC; i++) if (hs[i]) void'(src_q[i].pop_front());
        if (hold_cnt > 0) hold_cnt--;
        if (hold_trig >= 0 && src_q[1].size() == hold_trig) begin
            hold_cnt  = 5;
            hold_trig = -1;
        end
        if (toggle_rdy != 0) m_tready = ~m_tready;
        applyStimulus();
    endtask

    task automatic run_until_done(input int n, input int bound);
        for (int c = 0; c < bound && done_log.size() < n; c++) tick();
        checkOutput("done_count", 64'(done_log.size()), 64'(n));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
        out_log.delete();
        done_log.delete();
        hold_cnt = 0;
        hold_trig = -1;
        toggle_rdy = 0;
        watch_ready0 = 0;
        ready0_hits = 0;
        m_tready = 1'b1;
        applyStimulus();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        done_t d;
        out_t  o;
        rst_n    = 1'b0;
        m_tready = 1'b1;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;

        // Reset state and a single 3-beat packet from source 0.
        do_reset();
        checkOutput("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        checkOutput("rst_s_tready", 64'(s_tready), 64'd0);
        checkOutput("rst_pkt_len", 64'(len_out), 64'd0);
        checkOutput("rst_pkt_src", 64'(src_out), 64'd0);
        checkOutput("rst_pkt_done", 64'(done_out), 64'd0);
        push_beat(0, mk_data(0, 0, 0), 8'hFF, 1'b0);
        push_beat(0, mk_data(0, 0, 1), 8'hFF, 1'b0);
        push_beat(0, mk_data(0, 0, 2), 8'h0F, 1'b1);
        applyStimulus();
        req_cyc = cycle;
        run_until_done(1, 20);
        repeat (3) tick();
        checkOutput("single_beats", 64'(out_log.size()), 64'd3);
        checkOutput("single_latency", 64'(get_out(0).cyc - req_cyc), 64'd1);
        for (int b = 0; b < 3; b++) begin
            o = get_out(b);
            checkOutput($sformatf("single_data%0d", b), o.data, mk_data(0, 0, b));
            checkOutput($sformatf("single_last%0d", b), 64'(o.last), 64'(b == 2));
        end
        d = get_done(0);
        checkOutput("single_len", 64'(d.len), 64'd20);
        checkOutput("single_src", 64'(d.src), 64'd0);
        checkOutput("single_pulses", 64'(done_log.size()), 64'd1);
        checkOutput("single_len_hold", 64'(len_out), 64'd20);

        // Fairness: both sources stream 2-beat packets back to back.
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 2; s++)
                for (int b = 0; b < 2; b++)
                    push_beat(s, mk_data(s, p, b), 8'hFF, b == 1);
        applyStimulus();
        run_until_done(4, 60);
        checkOutput("fair_beats", 64'(out_log.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            o = get_out(k);
            checkOutput($sformatf("fair_src%0d", k), 64'(o.src), 64'((k / 2) % 2));
            checkOutput($sformatf("fair_data%0d", k), o.data, mk_data((k / 2) % 2, k / 4, k % 2));
            checkOutput($sformatf("fair_cyc%0d", k), 64'(o.cyc - get_out(0).cyc), 64'((k / 2) * 3 + (k % 2)));
        end
        for (int k = 0; k < 4; k++) begin
            d = get_done(k);
            checkOutput($sformatf("fair_dsrc%0d", k), 64'(d.src), 64'(k % 2));
            checkOutput($sformatf("fair_dlen%0d", k), 64'(d.len), 64'd16);
        end

        // Backpressure and a 5-cycle tvalid gap on source 1 while source 0 waits.
        do_reset();
        toggle_rdy = 1;
        hold_trig = 2;
        push_beat(1, mk_data(1, 0, 0), 8'hFF, 1'b0);
        push_beat(1, mk_data(1, 0, 1), 8'hFF, 1'b0);
        push_beat(1, mk_data(1, 0, 2), 8'hFF, 1'b0);
        push_beat(1, mk_data(1, 0, 3), 8'h03, 1'b1);
        applyStimulus();
        tick();
        tick();
        watch_ready0 = 1;
        push_beat(0, mk_data(0, 7, 0), 8'hFF, 1'b1);
        applyStimulus();
        run_until_done(2, 200);
        checkOutput("stall_beats", 64'(out_log.size()), 64'd5);
        for (int k = 0; k < 4; k++) begin
            o = get_out(k);
            checkOutput($sformatf("stall_src%0d", k), 64'(o.src), 64'd1);
            checkOutput($sformatf("stall_data%0d", k), o.data, mk_data(1, 0, k));
        end
        checkOutput("stall_gap", 64'((get_out(2).cyc - get_out(1).cyc) >= 6), 64'd1);
        checkOutput("stall_ready0", 64'(ready0_hits), 64'd0);
        checkOutput("stall_src_last", 64'(get_out(4).src), 64'd0);
        checkOutput("stall_data_last", get_out(4).data, mk_data(0, 7, 0));
        d = get_done(0);
        checkOutput("stall_len1", 64'(d.len), 64'd26);
        checkOutput("stall_src1", 64'(d.src), 64'd1);
        d = get_done(1);
        checkOutput("stall_len0", 64'(d.len), 64'd8);
        checkOutput("stall_src0", 64'(d.src), 64'd0);

        // Keep decoding: 0x05 and 0x00 count zero; single-beat packet.
        do_reset();
        push_beat(0, mk_data(0, 0, 0), 8'hFF, 1'b0);
        push_beat(0, mk_data(0, 0, 1), 8'h05, 1'b1);
        push_beat(0, mk_data(0, 1, 0), 8'h07, 1'b1);
        push_beat(0, mk_data(0, 2, 0), 8'hFF, 1'b0);
        push_beat(0, mk_data(0, 2, 1), 8'h00, 1'b0);
        push_beat(0, mk_data(0, 2, 2), 8'hFF, 1'b1);
        applyStimulus();
        run_until_done(3, 40);
        checkOutput("keep05_len", 64'(get_done(0).len), 64'd8);
        checkOutput("keep07_len", 64'(get_done(1).len), 64'd3);
        checkOutput("keep00_len", 64'(get_done(2).len), 64'd16);
        checkOutput("onebeat_gap", 64'(get_out(2).cyc - get_out(1).cyc), 64'd2);

        // Length wrap: 8193 full beats = 65544 bytes, reported modulo 2^16.
        do_reset();
        for (int b = 0; b < 8193; b++) push_beat(0, mk_data(0, 0, b), 8'hFF, b == 8192);
        applyStimulus();
        run_until_done(1, 9000);
        checkOutput("wrap_beats", 64'(out_log.size()), 64'd8193);
        checkOutput("wrap_len", 64'(get_done(0).len), 64'd8);
        checkOutput("wrap_src", 64'(get_done(0).src), 64'd0);

        // Reset in the middle of a source-1 packet.
        out_log.delete();
        done_log.delete();
        for (int b = 0; b < 6; b++) push_beat(1, mk_data(1, 3, b), 8'hFF, b == 5);
        applyStimulus();
        for (int c = 0; c < 50 && src_q[1].size() > 3; c++) tick();
        checkOutput("midrst_progress", 64'(src_q[1].size()), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        checkOutput("midrst_m_tdata", m_tdata, 64'd0);
        checkOutput("midrst_s_tready", 64'(s_tready), 64'd0);
        checkOutput("midrst_pkt_len", 64'(len_out), 64'd0);
        checkOutput("midrst_pkt_done", 64'(done_out), 64'd0);
        checkOutput("midrst_no_done", 64'(done_log.size()), 64'd0);
        @(posedge clk);
        push_beat(0, mk_data(0, 9, 0), 8'h01, 1'b1);
        applyStimulus();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_log.delete();
        run_until_done(2, 40);
        checkOutput("postrst_first_src", 64'(get_out(0).src), 64'd0);
        checkOutput("postrst_len0", 64'(get_done(0).len), 64'd1);
        checkOutput("postrst_src0", 64'(get_done(0).src), 64'd0);
        checkOutput("postrst_len1", 64'(get_done(1).len), 64'd24);
        checkOutput("postrst_src1", 64'(get_done(1).src), 64'd1);
        checkOutput("postrst_data1", get_out(1).data, mk_data(1, 3, 3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_pkt_arbiter.md
# axis_pkt_arbiter

Packet-granular round-robin arbiter that merges `NUM_SRC` 64-bit AXI-Stream sources into one stream toward the UDP/IP TX path of the 10 Gbps stack. A grant is held from the first accepted beat to the accepted `tlast` beat, so packets are never interleaved. The block also reports the byte length and source index of every forwarded packet, for TX statistics and for the header builder downstream.

## Interface
- `NUM_SRC`, 2: number of requesting sources; legal range is 2..4.
- `LEN_W`, 16: width of the packet byte-length report.
- `axis_aclk` in 1: the single clock.
- `axis_aresetn` in 1: asynchronous, active-low reset.
- `s_axis_tvalid` in `NUM_SRC`: per-source valid.
- `s_axis_tready` out `NUM_SRC`: per-source ready.
- `s_axis_tdata` in `NUM_SRC*64`: flattened data; source i occupies bits [64i+63:64i].
- `s_axis_tkeep` in `NUM_SRC*8`: flattened keep.
- `s_axis_tlast` in `NUM_SRC`: per-source last.
- `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tdata` out 64, `m_axis_tkeep` out 8, `m_axis_tlast` out 1: merged output stream.
- `pkt_len_bytes` out `LEN_W`: byte count of the last completed packet.
- `pkt_src` out 2: source index of the last completed packet.
- `pkt_done` out 1: one-cycle pulse when `pkt_len_bytes` and `pkt_src` update.

## Operation
- FSM states:
  - IDLE: no grant.
  - BUSY: grant locked to the registered index `grant`.
- IDLE:
  - All `s_axis_tready`=0 and `m_axis_tvalid`=0.
  - If any `s_axis_tvalid` is set, select the first asserted source searching upward from `last_grant+1` modulo `NUM_SRC`.
  - Register the selection into `grant`, clear `acc`, and go to BUSY.
- BUSY:
  - Output signals are a combinational mux: `m_axis_* = s_axis_*[grant]`.
  - `s_axis_tready[grant] = m_axis_tready`; every other `s_axis_tready` is 0.
- Beat accepted (`m_axis_tvalid & m_axis_tready`) without `tlast`: `acc <= acc + kb(tkeep)`.
- Beat accepted with `tlast`:
  - `pkt_len_bytes <= acc + kb(tkeep)`, `pkt_src <= grant`, `pkt_done <= 1`.
  - `last_grant <= grant`, `acc <= 0`, go to IDLE.
- `kb(keep)` is the number of valid bytes in the beat:
  - Contiguous LSB-aligned masks 0x01, 0x03, …, 0xFF give 1..8.
  - Any other mask, including 0x00, gives 0.
- Arithmetic: `acc` is `LEN_W` bits and wraps modulo 2^`LEN_W` with no saturation and no error flag.
- A source whose `tvalid` drops mid-packet keeps the grant. The block waits indefinitely; there is no timeout.
- Non-granted sources never see `tready`=1, so their data is held by AXIS rules.
- No data path is added when `NUM_SRC`=1 (out of legal range).

## Timing
- Reset (asynchronous assert, synchronous deassert by the environment) forces:
  - state IDLE, `grant`=0, `last_grant`=`NUM_SRC-1` so source 0 wins first;
  - `acc`=0, `pkt_len_bytes`=0, `pkt_src`=0, `pkt_done`=0, all `tready`=0, `m_axis_tvalid`=0.
- Arbitration latency: a request seen in IDLE in cycle N gives the first beat presentable on `m_axis` in cycle N+1.
- Zero data latency through BUSY; the data path is combinational.
- Every packet is followed by exactly one IDLE bubble cycle, even for back-to-back packets from the same source.
- `pkt_done` asserts in the cycle after the `tlast` handshake, for exactly one cycle. `pkt_len_bytes` and `pkt_src` hold their values until the next `pkt_done`.
- A single-beat packet (`tlast` on its first beat) is legal: IDLE → BUSY → IDLE over 2 cycles.
- Reset mid-packet drops the partial packet:
  - no `pkt_done` is produced;
  - the upstream remainder is delivered after reset as a new packet.

## Structure
- Shared package `udp_axis_pkg`:
  - `AXIS_DATA_W`=64 and `AXIS_KEEP_W`=8;
  - the `kb` keep-to-byte-count function, which the existing stream byte counter also uses.
- Sub-module `rr_select`: a combinational round-robin picker with inputs `req[NUM_SRC]` and `last[1:0]`, and outputs `gnt_idx` and `any`.
- The FSM, length accumulator and muxing live in the top module.

## Test plan
- **Single source:** source 0 sends 3 beats with keep FF, FF, 0F and `tlast` on beat 3, `m_axis_tready`=1. Required: 3 output beats starting 1 cycle after the request, then `pkt_done` with `pkt_len_bytes`=20 and `pkt_src`=0.
- **Fairness:** sources 0 and 1 both stream continuous 2-beat packets. Required: grants alternate 0,1,0,1 with one bubble cycle between packets, and no beat of one packet ever appears inside another.
- **Backpressure / stall:** `m_axis_tready` toggles every cycle, and source 1 drops `tvalid` for 5 cycles mid-packet. Required: the grant stays on 1, `s_axis_tready[0]` stays 0 throughout, and data order and the length count are exact.
- **Non-contiguous keep:** a beat with keep 0x05 inside a 2-beat packet (other beat FF). Required: that beat counts 0, so `pkt_len_bytes`=8.
- **Wrap and reset:** an 8193-beat packet of keep FF gives `pkt_len_bytes`=(65544 mod 65536)=8. Asserting reset mid-packet clears all outputs to 0 within the same cycle, with no `pkt_done`, and source 0 is granted first after release.
